tick_period_meter: RTL
======================

// Module: tick_period_meter
// PURPOSE
//  Receive-side checker for the FD one-cycle strobe (default period 25,000,001 iClk).
//  Measures iClk cycles between rising edges of iTick and flags in/out-of-window periods.
//  Declares lock after LOCK_N consecutive good periods and detects a missing strobe (timeout).
//  Sits beside FD / the VGA timing logic as a self-check and debug monitor.
// PARAMETERS
//  CNT_W        26          width of oPeriod and internal counter; must hold TIMEOUT
//  EXPECTED     25000001    nominal period in iClk cycles
//  TOL          0           allowed |period-EXPECTED| for a good measurement
//  TIMEOUT      50000000    cycles without an edge before timeout (> EXPECTED+TOL)
//  LOCK_N       4           consecutive good periods required for lock (1..15)
//  SYNC_STAGES  0           synchronizer flops on iTick (0 = same clock domain)
// PORTS
//  iClk      in   1      clock
//  iRst_n    in   1      asynchronous active-low reset
//  iTick     in   1      strobe to measure; level, rising edge is the event
//  iClear    in   1      synchronous clear of state and statistics
//  oPeriod   out  CNT_W  last measured period, held between measurements
//  oValid    out  1      one-cycle pulse when oPeriod updates
//  oInWin    out  1      last measurement within EXPECTED+/-TOL, held
//  oLock     out  1      LOCK_N consecutive good periods, no timeout since
//  oTimeout  out  1      sticky: no edge for TIMEOUT cycles; cleared on next edge
//  oErrCnt   out  8      saturating count of bad periods plus timeouts
// BEHAVIOUR
//  Reset (iRst_n=0, async): state IDLE, all outputs 0, counter 0, good-run 0.
//  Edge event E: iTick after SYNC_STAGES flops is 1 and was 0 the previous cycle.
//   Latency from iTick high to E (and to oValid) is fixed: SYNC_STAGES+1 cycles.
//   A held-high iTick gives one E; a 1-cycle pulse is enough when SYNC_STAGES=0.
//  Counter: on E load 1, else increment, saturate at TIMEOUT.
//   Edges P cycles apart give oPeriod=P, so an ideal FD gives EXPECTED.
//  FSM states IDLE, MEASURE, LOST:
//   IDLE: counter held 0; on E -> MEASURE (reference edge only, no oValid).
//   MEASURE on E: oPeriod<=counter, oValid=1 for 1 cycle, oInWin<=good.
//    Good: |counter-EXPECTED| <= TOL, computed with CNT_W+1 bits, no wrap.
//    Good: good-run+1, saturating at LOCK_N; oLock=1 when it reaches LOCK_N.
//    Bad: good-run 0, oLock 0, oErrCnt+1 (saturating at 255).
//    oLock/oInWin/oErrCnt update in the same cycle as oValid.
//    Stay in MEASURE.
//   MEASURE, no E, counter==TIMEOUT: -> LOST, oTimeout=1, oLock=0, good-run 0,
//    oErrCnt+1 (saturating); oPeriod and oInWin keep their values.
//   LOST: counter stays saturated; on E -> MEASURE, oTimeout=0, counter=1, no oValid.
//  Simultaneous E and counter==TIMEOUT in MEASURE: the edge wins and is measured.
//   oPeriod=TIMEOUT (bad), no timeout flagged.
//  iClear=1: next state IDLE; all outputs and counters as at reset.
//   An E in the same cycle is discarded. Synchronizer flops are not cleared.
//   The edge-detect history flop is also kept, so a held-high iTick gives no false E.
//  Reset mid-measurement: back to IDLE at once, as at power-up.
// TESTING (EXPECTED=10, TOL=1, TIMEOUT=32, LOCK_N=3, SYNC_STAGES=0 unless noted)
//  1 Pulses every 10 cycles x5 -> first pulse no oValid; then 4 oValid with oPeriod=10.
//    Same cases: oInWin=1; oLock rises on the 3rd oValid; oErrCnt=0.
//  2 Locked, then gaps 11, 9, 12 -> 11 and 9 keep lock.
//    12 -> oInWin=0, oLock=0, oErrCnt=1 in the same cycle as oValid.
//  3 Pulses stop after lock -> 32 cycles after the last edge oTimeout=1, oLock=0, oErrCnt+1.
//    Next pulse -> oTimeout=0 with no oValid; pulse 10 cycles later -> oValid, oPeriod=10.
//  4 iTick held high 25 cycles, low 5 cycles, repeated -> one E per rising edge.
//    Measured oPeriod=30 (bad); a high level never counts as a second edge.
//  5 iClear on the cycle of an E while locked -> all outputs 0, state IDLE, that edge ignored.
//    Next E is a reference only; following E gives the first oValid.
//  6 SYNC_STAGES=2, 10-cycle pulses -> oValid 3 cycles after each iTick rise, oPeriod=10.
//    iRst_n low mid-period -> outputs 0 immediately, without waiting for iClk.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Receive-side monitor for a one-cycle strobe (the FD tick). It counts iClk
//   cycles between rising edges of iTick, reports each measured period, flags
//   whether it fell inside EXPECTED +/- TOL, declares lock after LOCK_N good
//   periods in a row and raises a sticky timeout when the strobe goes missing.
//
// Ports
//   iClk      in   1      clock
//   iRst_n    in   1      asynchronous active-low reset
//   iTick     in   1      strobe level; its rising edge is the measured event
//   iClear    in   1      synchronous clear of state and statistics
//   oPeriod   out  CNT_W  last measured period, held between measurements
//   oValid    out  1      one-cycle pulse when oPeriod updates
//   oInWin    out  1      last measurement was within EXPECTED +/- TOL
//   oLock     out  1      LOCK_N consecutive good periods, no timeout since
//   oTimeout  out  1      no edge for TIMEOUT cycles; cleared by the next edge
//   oErrCnt   out  8      saturating count of bad periods plus timeouts
module tick_period_meter #(
    parameter int CNT_W       = 26,
    parameter int EXPECTED    = 25000001,
    parameter int TOL         = 0,
    parameter int TIMEOUT     = 50000000,
    parameter int LOCK_N      = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iTick,
    input  logic             iClear,
    output logic [CNT_W-1:0] oPeriod,
    output logic             oValid,
    output logic             oInWin,
    output logic             oLock,
    output logic             oTimeout,
    output logic [7:0]       oErrCnt
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_X     = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

    logic             tick_s;
    logic             tick_prev_q;
    logic             tick_edge;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             in_win_q, in_win_d;
    logic             lock_q, lock_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [3:0]       good_run_q, good_run_d;

    logic [CNT_W:0]   count_x;
    logic [CNT_W:0]   diff;
    logic             good;
    logic [CNT_W-1:0] count_inc;
    logic [7:0]       err_inc;
    logic [3:0]       good_run_inc;

    // Optional synchronizer chain. It is only reset by iRst_n, never by
    // iClear, so a clear cannot manufacture or swallow an edge in flight.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign tick_s = iTick;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= iTick;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign tick_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign tick_edge = tick_s & ~tick_prev_q;

    // Distance from nominal is taken one bit wider than the counter so the
    // subtraction can never wrap into a falsely small value.
    assign count_x      = {1'b0, count_q};
    assign diff         = (count_x >= EXP_X) ? (count_x - EXP_X) : (EXP_X - count_x);
    assign good         = (diff <= TOL_X);
    assign count_inc    = (count_q < TIMEOUT_C) ? (count_q + CNT_W'(1)) : count_q;
    assign err_inc      = (err_cnt_q != 8'hFF) ? (err_cnt_q + 8'd1) : err_cnt_q;
    assign good_run_inc = (good_run_q < LOCK_C) ? (good_run_q + 4'd1) : good_run_q;

    // Next-state logic. An edge in MEASURE takes priority over the timeout
    // check, so an edge landing exactly on TIMEOUT is measured, not lost.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_win_d   = in_win_q;
        lock_d     = lock_q;
        timeout_d  = timeout_q;
        err_cnt_d  = err_cnt_q;
        good_run_d = good_run_q;

        if (iClear) begin
            state_d    = IDLE;
            count_d    = '0;
            period_d   = '0;
            in_win_d   = 1'b0;
            lock_d     = 1'b0;
            timeout_d  = 1'b0;
            err_cnt_d  = '0;
            good_run_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (tick_edge) begin
                        state_d = MEASURE;
                        count_d = CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (tick_edge) begin
                        count_d  = CNT_W'(1);
                        period_d = count_q;
                        valid_d  = 1'b1;
                        in_win_d = good;
                        if (good) begin
                            good_run_d = good_run_inc;
                            lock_d     = (good_run_inc == LOCK_C);
                        end else begin
                            good_run_d = '0;
                            lock_d     = 1'b0;
                            err_cnt_d  = err_inc;
                        end
                    end else if (count_q == TIMEOUT_C) begin
                        state_d    = LOST;
                        timeout_d  = 1'b1;
                        lock_d     = 1'b0;
                        good_run_d = '0;
                        err_cnt_d  = err_inc;
                    end else begin
                        count_d = count_inc;
                    end
                end
                LOST: begin
                    if (tick_edge) begin
                        state_d   = MEASURE;
                        timeout_d = 1'b0;
                        count_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and output registers. The edge history flop follows the
    // synchronized tick even through iClear so a held-high tick is not
    // mistaken for a new edge once the clear drops.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            tick_prev_q <= 1'b0;
            count_q     <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            in_win_q    <= 1'b0;
            lock_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            good_run_q  <= '0;
        end else begin
            state_q     <= state_d;
            tick_prev_q <= tick_s;
            count_q     <= count_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            in_win_q    <= in_win_d;
            lock_q      <= lock_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            good_run_q  <= good_run_d;
        end
    end

    assign oPeriod  = period_q;
    assign oValid   = valid_q;
    assign oInWin   = in_win_q;
    assign oLock    = lock_q;
    assign oTimeout = timeout_q;
    assign oErrCnt  = err_cnt_q;

endmodule
